// File: rtl/simpledma_axi_pkg.sv
// Shared AXI response/burst encodings and FSM state types for the burst memory slave.
package simpledma_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

    // A burst is served normally only for FIXED/INCR at the native bus width;
    // WRAP, the reserved encoding and narrow/wide transfers are all rejected.
    function automatic logic burst_is_bad(input logic [1:0] burst,
                                          input logic [2:0] size,
                                          input logic [2:0] native_size);
        return ((burst != BURST_FIXED) && (burst != BURST_INCR)) || (size != native_size);
    endfunction

endpackage

// File: rtl/axi_mem_slave_ram.sv
// Single-clock RAM: one byte-enabled write port and one registered read port.
// A read and write to the same word in the same cycle returns the old contents.
module axi_mem_slave_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [DEPTH_LOG2-1:0]   waddr,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic                    re,
    input  logic [DEPTH_LOG2-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int DEPTH     = 1 << DEPTH_LOG2;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Byte-lane writes; contents are deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Registered read that only updates when a new beat is requested, so the
    // output holds steady while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/axi_burst_mem_slave.sv
// AXI4 burst memory slave: independent write and read FSMs around a byte-enable RAM,
// one outstanding transaction per direction, INCR/FIXED bursts only.
module axi_burst_mem_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int MEM_DEPTH_LOG2     = 10
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]                      S_AXI_AWLEN,
    input  logic [2:0]                      S_AXI_AWSIZE,
    input  logic [1:0]                      S_AXI_AWBURST,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WLAST,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]                      S_AXI_ARLEN,
    input  logic [2:0]                      S_AXI_ARSIZE,
    input  logic [1:0]                      S_AXI_ARBURST,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RLAST,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);

    import simpledma_axi_pkg::*;

    localparam int                       STRB_WIDTH  = C_S_AXI_DATA_WIDTH / 8;
    localparam int                       ADDR_LSB    = $clog2(STRB_WIDTH);
    localparam logic [2:0]               NATIVE_SIZE = 3'(ADDR_LSB);
    localparam logic [MEM_DEPTH_LOG2-1:0] INDEX_ONE  = 1;

    // Address bits outside the word index are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{S_AXI_AWADDR, S_AXI_ARADDR};

    logic ready_en;

    w_state_e                    w_state, w_state_next;
    logic [C_S_AXI_ID_WIDTH-1:0] w_id;
    logic [MEM_DEPTH_LOG2-1:0]   w_index;
    logic [7:0]                  w_len, w_beat;
    logic                        w_fixed, w_bad, w_err;
    logic                        aw_hs, w_hs, w_last_beat;

    r_state_e                    r_state, r_state_next;
    logic [C_S_AXI_ID_WIDTH-1:0] r_id;
    logic [MEM_DEPTH_LOG2-1:0]   r_index, r_next_index, ram_raddr;
    logic [7:0]                  r_len, r_beat;
    logic                        r_fixed, r_bad, r_last;
    logic                        ar_hs, r_hs, ram_re;
    logic [C_S_AXI_DATA_WIDTH-1:0] ram_rdata;

    assign aw_hs       = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs        = S_AXI_WVALID && S_AXI_WREADY;
    assign w_last_beat = (w_beat == w_len);
    assign ar_hs       = S_AXI_ARVALID && S_AXI_ARREADY;
    assign r_hs        = S_AXI_RVALID && S_AXI_RREADY;

    // Holds the address channels closed for the first cycle after reset releases.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // Write FSM state register.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_state_next;
        end
    end

    // Write FSM transitions and channel handshake outputs.
    always_comb begin
        w_state_next  = w_state;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        case (w_state)
            W_IDLE: begin
                S_AXI_AWREADY = ready_en;
                if (S_AXI_AWVALID && ready_en) begin
                    w_state_next = W_DATA;
                end
            end
            W_DATA: begin
                S_AXI_WREADY = 1'b1;
                if (S_AXI_WVALID && w_last_beat) begin
                    w_state_next = W_RESP;
                end
            end
            W_RESP: begin
                S_AXI_BVALID = 1'b1;
                if (S_AXI_BREADY) begin
                    w_state_next = W_IDLE;
                end
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    // Write burst bookkeeping: capture on AW, advance per beat, flag WLAST misplacement.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_id    <= '0;
            w_index <= '0;
            w_len   <= '0;
            w_beat  <= '0;
            w_fixed <= 1'b0;
            w_bad   <= 1'b0;
            w_err   <= 1'b0;
        end else if (aw_hs) begin
            w_id    <= S_AXI_AWID;
            w_index <= S_AXI_AWADDR[ADDR_LSB +: MEM_DEPTH_LOG2];
            w_len   <= S_AXI_AWLEN;
            w_beat  <= '0;
            w_fixed <= (S_AXI_AWBURST == BURST_FIXED);
            w_bad   <= burst_is_bad(S_AXI_AWBURST, S_AXI_AWSIZE, NATIVE_SIZE);
            w_err   <= burst_is_bad(S_AXI_AWBURST, S_AXI_AWSIZE, NATIVE_SIZE);
        end else if (w_hs) begin
            w_beat <= w_beat + 8'd1;
            if (!w_fixed) begin
                w_index <= w_index + INDEX_ONE;
            end
            if (S_AXI_WLAST != w_last_beat) begin
                w_err <= 1'b1;
            end
        end
    end

    assign S_AXI_BID   = w_id;
    assign S_AXI_BRESP = (S_AXI_BVALID && w_err) ? RESP_SLVERR : RESP_OKAY;

    // Read FSM state register.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_state_next;
        end
    end

    // Read FSM transitions and channel handshake outputs.
    always_comb begin
        r_state_next  = r_state;
        S_AXI_ARREADY = 1'b0;
        S_AXI_RVALID  = 1'b0;
        case (r_state)
            R_IDLE: begin
                S_AXI_ARREADY = ready_en;
                if (S_AXI_ARVALID && ready_en) begin
                    r_state_next = R_DATA;
                end
            end
            R_DATA: begin
                S_AXI_RVALID = 1'b1;
                if (S_AXI_RREADY && r_last) begin
                    r_state_next = R_IDLE;
                end
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    // The RAM is read on the AR handshake for beat 0 and on every R handshake
    // for the following beat, so data is ready the cycle it is needed.
    assign r_next_index = r_fixed ? r_index : (r_index + INDEX_ONE);
    assign ram_raddr    = (r_state == R_IDLE) ? S_AXI_ARADDR[ADDR_LSB +: MEM_DEPTH_LOG2] : r_next_index;
    assign ram_re       = ar_hs || (r_hs && !r_last);

    // Read burst bookkeeping: index/beat of the word currently presented and its RLAST.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_id    <= '0;
            r_index <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_fixed <= 1'b0;
            r_bad   <= 1'b0;
            r_last  <= 1'b0;
        end else if (ar_hs) begin
            r_id    <= S_AXI_ARID;
            r_index <= S_AXI_ARADDR[ADDR_LSB +: MEM_DEPTH_LOG2];
            r_len   <= S_AXI_ARLEN;
            r_beat  <= '0;
            r_fixed <= (S_AXI_ARBURST == BURST_FIXED);
            r_bad   <= burst_is_bad(S_AXI_ARBURST, S_AXI_ARSIZE, NATIVE_SIZE);
            r_last  <= (S_AXI_ARLEN == 8'd0);
        end else if (r_hs) begin
            if (r_last) begin
                r_last <= 1'b0;
            end else begin
                r_beat  <= r_beat + 8'd1;
                r_index <= r_next_index;
                r_last  <= ((r_beat + 8'd1) == r_len);
            end
        end
    end

    assign S_AXI_RID   = r_id;
    assign S_AXI_RDATA = r_bad ? '0 : ram_rdata;
    assign S_AXI_RRESP = (S_AXI_RVALID && r_bad) ? RESP_SLVERR : RESP_OKAY;
    assign S_AXI_RLAST = r_last;

    axi_mem_slave_ram #(
        .DATA_WIDTH (C_S_AXI_DATA_WIDTH),
        .DEPTH_LOG2 (MEM_DEPTH_LOG2)
    ) u_ram (
        .clk   (ACLK),
        .rst   (ARESET),
        .we    (w_hs && !w_bad),
        .waddr (w_index),
        .wstrb (S_AXI_WSTRB),
        .wdata (S_AXI_WDATA),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Testbench for axi_burst_mem_slave: table of burst vectors, hand-written corner
// sequences and randomized bursts, all checked against a word-array memory model.
module tb_axi_burst_mem_slave;

    localparam int DEPTH = 1024;

    logic        ACLK, ARESET;
    logic [0:0]  S_AXI_AWID, S_AXI_BID, S_AXI_ARID, S_AXI_RID;
    logic [31:0] S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_WDATA, S_AXI_RDATA;
    logic [7:0]  S_AXI_AWLEN, S_AXI_ARLEN;
    logic [2:0]  S_AXI_AWSIZE, S_AXI_ARSIZE;
    logic [1:0]  S_AXI_AWBURST, S_AXI_ARBURST, S_AXI_BRESP, S_AXI_RRESP;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WLAST, S_AXI_WVALID, S_AXI_WREADY;
    logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
    logic        S_AXI_RLAST, S_AXI_RVALID, S_AXI_RREADY;

    axi_burst_mem_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (32),
        .C_S_AXI_ID_WIDTH   (1),
        .MEM_DEPTH_LOG2     (10)
    ) dut (
        .ACLK (ACLK), .ARESET (ARESET),
        .S_AXI_AWID (S_AXI_AWID), .S_AXI_AWADDR (S_AXI_AWADDR), .S_AXI_AWLEN (S_AXI_AWLEN),
        .S_AXI_AWSIZE (S_AXI_AWSIZE), .S_AXI_AWBURST (S_AXI_AWBURST),
        .S_AXI_AWVALID (S_AXI_AWVALID), .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA (S_AXI_WDATA), .S_AXI_WSTRB (S_AXI_WSTRB), .S_AXI_WLAST (S_AXI_WLAST),
        .S_AXI_WVALID (S_AXI_WVALID), .S_AXI_WREADY (S_AXI_WREADY),
        .S_AXI_BID (S_AXI_BID), .S_AXI_BRESP (S_AXI_BRESP),
        .S_AXI_BVALID (S_AXI_BVALID), .S_AXI_BREADY (S_AXI_BREADY),
        .S_AXI_ARID (S_AXI_ARID), .S_AXI_ARADDR (S_AXI_ARADDR), .S_AXI_ARLEN (S_AXI_ARLEN),
        .S_AXI_ARSIZE (S_AXI_ARSIZE), .S_AXI_ARBURST (S_AXI_ARBURST),
        .S_AXI_ARVALID (S_AXI_ARVALID), .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RID (S_AXI_RID), .S_AXI_RDATA (S_AXI_RDATA), .S_AXI_RRESP (S_AXI_RRESP),
        .S_AXI_RLAST (S_AXI_RLAST), .S_AXI_RVALID (S_AXI_RVALID), .S_AXI_RREADY (S_AXI_RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] model_mem  [DEPTH];
    logic [31:0] wbeat_data [256];
    logic [3:0]  wbeat_strb [256];
    logic [31:0] rbeat_data [256];
    logic        rbeat_last [256];

    typedef struct {
        logic [31:0] addr;
        int          len;
        logic [1:0]  awburst;
        logic [2:0]  awsize;
        logic [3:0]  strb;
        int          wlast_at;
        logic [1:0]  arburst;
        logic [2:0]  arsize;
        logic [1:0]  exp_bresp;
        logic [1:0]  exp_rresp;
    } vec_t;

    vec_t        table_v [11];
    logic [1:0]  resp;
    logic [31:0] r_addr;
    int          r_len, r_wlast;
    logic [1:0]  r_burst, r_arburst;
    logic [2:0]  r_size, r_arsize;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic bit model_bad(input logic [1:0] burst, input logic [2:0] size);
        return !(burst == 2'b00 || burst == 2'b01) || (size != 3'd2);
    endfunction

    function automatic int model_word(input logic [31:0] addr, input int beat, input logic [1:0] burst);
        int base;
        base = int'((addr >> 2) % DEPTH);
        return (burst == 2'b00) ? base : (base + beat) % DEPTH;
    endfunction

    function automatic logic [31:0] model_read_word(input logic [31:0] addr, input int beat,
                                                    input logic [1:0] burst, input logic [2:0] size);
        return model_bad(burst, size) ? 32'h0 : model_mem[model_word(addr, beat, burst)];
    endfunction

    task automatic model_write(input logic [31:0] addr, input int len, input logic [1:0] burst, input logic [2:0] size);
        int w;
        if (!model_bad(burst, size)) begin
            for (int beat = 0; beat <= len; beat++) begin
                w = model_word(addr, beat, burst);
                for (int b = 0; b < 4; b++) begin
                    if (wbeat_strb[beat][b]) model_mem[w][b*8 +: 8] = wbeat_data[beat][b*8 +: 8];
                end
            end
        end
    endtask

    task automatic apply_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                               input logic [2:0] size, input int wlast_at, input int bready_hold,
                               input bit gaps, output logic [1:0] bresp);
        int cnt;
        logic id;
        bresp = 2'b11;
        @(negedge ACLK);
        id = 1'($urandom);
        S_AXI_AWID = id; S_AXI_AWADDR = addr; S_AXI_AWLEN = 8'(len);
        S_AXI_AWSIZE = size; S_AXI_AWBURST = burst; S_AXI_AWVALID = 1'b1;
        cnt = 0;
        while (S_AXI_AWREADY !== 1'b1 && cnt < 50) begin @(negedge ACLK); cnt++; end
        check_output("aw_ready", S_AXI_AWREADY, 1'b1);
        @(negedge ACLK);
        S_AXI_AWVALID = 1'b0;
        for (int beat = 0; beat <= len; beat++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                S_AXI_WVALID = 1'b0;
                @(negedge ACLK);
            end
            S_AXI_WVALID = 1'b1; S_AXI_WDATA = wbeat_data[beat]; S_AXI_WSTRB = wbeat_strb[beat];
            S_AXI_WLAST = (beat == wlast_at);
            cnt = 0;
            while (S_AXI_WREADY !== 1'b1 && cnt < 50) begin @(negedge ACLK); cnt++; end
            if (cnt >= 50) begin
                check_output("w_ready", S_AXI_WREADY, 1'b1);
                break;
            end
            @(negedge ACLK);
        end
        S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
        cnt = 0;
        while (S_AXI_BVALID !== 1'b1 && cnt < 50) begin @(negedge ACLK); cnt++; end
        check_output("b_valid", S_AXI_BVALID, 1'b1);
        bresp = S_AXI_BRESP;
        check_output("bid", S_AXI_BID, id);
        for (int i = 0; i < bready_hold; i++) begin
            @(negedge ACLK);
            check_output("bvalid_hold", S_AXI_BVALID, 1'b1);
            check_output("bresp_hold", S_AXI_BRESP, bresp);
        end
        S_AXI_BREADY = 1'b1;
        @(negedge ACLK);
        S_AXI_BREADY = 1'b0;
        check_output("bvalid_clear", S_AXI_BVALID, 1'b0);
    endtask

    task automatic apply_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                              input logic [2:0] size, input logic [1:0] exp_rresp, input int mode);
        int cnt, got;
        logic id;
        @(negedge ACLK);
        id = 1'($urandom);
        S_AXI_ARID = id; S_AXI_ARADDR = addr; S_AXI_ARLEN = 8'(len);
        S_AXI_ARSIZE = size; S_AXI_ARBURST = burst; S_AXI_ARVALID = 1'b1;
        cnt = 0;
        while (S_AXI_ARREADY !== 1'b1 && cnt < 50) begin @(negedge ACLK); cnt++; end
        check_output("ar_ready", S_AXI_ARREADY, 1'b1);
        @(negedge ACLK);
        S_AXI_ARVALID = 1'b0;
        check_output("rvalid_latency", S_AXI_RVALID, 1'b1);
        got = 0; cnt = 0;
        while (got <= len && cnt < 4000) begin
            case (mode)
                0:       S_AXI_RREADY = 1'b1;
                1:       S_AXI_RREADY = 1'($urandom_range(0, 1));
                default: S_AXI_RREADY = 1'(cnt % 2);
            endcase
            if (S_AXI_RVALID === 1'b1) begin
                check_output("rdata", S_AXI_RDATA, model_read_word(addr, got, burst, size));
                check_output("rresp", S_AXI_RRESP, exp_rresp);
                check_output("rlast", S_AXI_RLAST, (got == len));
                check_output("rid", S_AXI_RID, id);
                if (S_AXI_RREADY) begin
                    rbeat_data[got] = S_AXI_RDATA;
                    rbeat_last[got] = S_AXI_RLAST;
                    got++;
                end
            end
            @(negedge ACLK);
            cnt++;
        end
        S_AXI_RREADY = 1'b0;
        check_output("r_beats", 64'(got), 64'(len + 1));
        check_output("rvalid_idle", S_AXI_RVALID, 1'b0);
    endtask

    task automatic fill_random(input int len, input logic [3:0] strb);
        for (int i = 0; i <= len; i++) begin
            wbeat_data[i] = $urandom;
            wbeat_strb[i] = (strb == 4'h0) ? 4'($urandom) : strb;
        end
    endtask

    initial begin
        ARESET = 1'b1;
        S_AXI_AWID = '0; S_AXI_AWADDR = '0; S_AXI_AWLEN = '0; S_AXI_AWSIZE = '0; S_AXI_AWBURST = '0;
        S_AXI_AWVALID = 1'b0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b0; S_AXI_ARID = '0; S_AXI_ARADDR = '0; S_AXI_ARLEN = '0; S_AXI_ARSIZE = '0;
        S_AXI_ARBURST = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;

        // Reset state and the one-cycle delay before the address channels open.
        repeat (3) @(negedge ACLK);
        check_output("reset_outputs", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP, S_AXI_BID,
                     S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RID}, 64'h0);
        ARESET = 1'b0;
        #1 check_output("awready_at_release", S_AXI_AWREADY, 1'b0);
        @(negedge ACLK);
        check_output("awready_after_release", S_AXI_AWREADY, 1'b1);
        check_output("arready_after_release", S_AXI_ARREADY, 1'b1);

        // Clear the whole RAM so every later read has a known expected value.
        for (int k = 0; k < 4; k++) begin
            fill_random(255, 4'hF);
            for (int i = 0; i < 256; i++) wbeat_data[i] = 32'h0;
            apply_write(32'(k * 1024), 255, 2'b01, 3'd2, 255, 0, 1'b0, resp);
            check_output("init_bresp", resp, 2'b00);
            model_write(32'(k * 1024), 255, 2'b01, 3'd2);
        end

        // INCR burst of 1..4 and its readback.
        for (int i = 0; i < 4; i++) begin wbeat_data[i] = 32'(i + 1); wbeat_strb[i] = 4'hF; end
        apply_write(32'h40, 3, 2'b01, 3'd2, 3, 0, 1'b0, resp);
        check_output("incr4_bresp", resp, 2'b00);
        model_write(32'h40, 3, 2'b01, 3'd2);
        apply_read(32'h40, 3, 2'b01, 3'd2, 2'b00, 0);
        for (int i = 0; i < 4; i++) check_output("incr4_data", rbeat_data[i], 64'(i + 1));
        check_output("incr4_rlast", rbeat_last[3], 1'b1);

        // Partial strobes over a zero word.
        wbeat_data[0] = 32'hFFFF_FFFF; wbeat_strb[0] = 4'b0101;
        apply_write(32'h80, 0, 2'b01, 3'd2, 0, 0, 1'b0, resp);
        model_write(32'h80, 0, 2'b01, 3'd2);
        apply_read(32'h80, 0, 2'b01, 3'd2, 2'b00, 0);
        check_output("strb_0101", rbeat_data[0], 32'h00FF_00FF);

        // Table-driven bursts.
        table_v[0]  = '{32'h0000_0100,  0, 2'b01, 3'd2, 4'hF,  -1, 2'b01, 3'd2, 2'b00, 2'b00};
        table_v[1]  = '{32'h0000_0200,  7, 2'b00, 3'd2, 4'h0,  -1, 2'b00, 3'd2, 2'b00, 2'b00};
        table_v[2]  = '{32'h0000_0300,  3, 2'b10, 3'd2, 4'hF,  -1, 2'b01, 3'd2, 2'b10, 2'b00};
        table_v[3]  = '{32'h0000_0380,  1, 2'b01, 3'd1, 4'hF,  -1, 2'b01, 3'd2, 2'b10, 2'b00};
        table_v[4]  = '{32'h0000_0400,  3, 2'b01, 3'd2, 4'hF,   2, 2'b01, 3'd2, 2'b10, 2'b00};
        table_v[5]  = '{32'h0000_0480,  3, 2'b01, 3'd2, 4'hF, 300, 2'b01, 3'd2, 2'b10, 2'b00};
        table_v[6]  = '{32'hABCD_0500,  5, 2'b01, 3'd2, 4'h3,  -1, 2'b01, 3'd2, 2'b00, 2'b00};
        table_v[7]  = '{32'h0000_0FF0,  7, 2'b01, 3'd2, 4'h0,  -1, 2'b01, 3'd2, 2'b00, 2'b00};
        table_v[8]  = '{32'h0000_0600,  3, 2'b01, 3'd2, 4'hF,  -1, 2'b10, 3'd2, 2'b00, 2'b10};
        table_v[9]  = '{32'h0000_0640,  2, 2'b01, 3'd2, 4'hF,  -1, 2'b00, 3'd3, 2'b00, 2'b10};
        table_v[10] = '{32'h0000_0680, 15, 2'b01, 3'd2, 4'h0,  -1, 2'b01, 3'd2, 2'b00, 2'b00};
        for (int t = 0; t < 11; t++) begin
            fill_random(table_v[t].len, table_v[t].strb);
            apply_write(table_v[t].addr, table_v[t].len, table_v[t].awburst, table_v[t].awsize,
                        (table_v[t].wlast_at == -1) ? table_v[t].len : table_v[t].wlast_at, 0, 1'b1, resp);
            check_output($sformatf("tbl%0d_bresp", t), resp, table_v[t].exp_bresp);
            model_write(table_v[t].addr, table_v[t].len, table_v[t].awburst, table_v[t].awsize);
            apply_read(table_v[t].addr, table_v[t].len, table_v[t].arburst, table_v[t].arsize,
                       table_v[t].exp_rresp, 0);
        end

        // 256-beat INCR from the last word wraps around to index 0.
        fill_random(255, 4'hF);
        apply_write(32'h0000_0FFC, 255, 2'b01, 3'd2, 255, 0, 1'b0, resp);
        check_output("wrap256_bresp", resp, 2'b00);
        model_write(32'h0000_0FFC, 255, 2'b01, 3'd2);
        apply_read(32'h0000_0FFC, 255, 2'b01, 3'd2, 2'b00, 1);
        check_output("wrap256_index0", rbeat_data[1], wbeat_data[1]);

        // 16-beat read with RREADY alternating every cycle.
        apply_read(32'h0000_0680, 15, 2'b01, 3'd2, 2'b00, 2);

        // BREADY held low for 5 cycles on an error response.
        fill_random(1, 4'hF);
        apply_write(32'h0000_0740, 1, 2'b10, 3'd2, 1, 5, 1'b0, resp);
        check_output("bhold_bresp", resp, 2'b10);

        // Reset asserted while beat 2 of a 4-beat write is being offered.
        fill_random(3, 4'hF);
        @(negedge ACLK);
        S_AXI_AWADDR = 32'h0000_07C0; S_AXI_AWLEN = 8'd3; S_AXI_AWSIZE = 3'd2;
        S_AXI_AWBURST = 2'b01; S_AXI_AWVALID = 1'b1;
        for (int c = 0; c < 50 && S_AXI_AWREADY !== 1'b1; c++) @(negedge ACLK);
        @(negedge ACLK);
        S_AXI_AWVALID = 1'b0;
        for (int beat = 0; beat < 2; beat++) begin
            S_AXI_WVALID = 1'b1; S_AXI_WDATA = wbeat_data[beat]; S_AXI_WSTRB = 4'hF; S_AXI_WLAST = 1'b0;
            for (int c = 0; c < 50 && S_AXI_WREADY !== 1'b1; c++) @(negedge ACLK);
            @(negedge ACLK);
        end
        S_AXI_WDATA = wbeat_data[2];
        #2 ARESET = 1'b1;
        #1 check_output("midreset_outputs", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP, S_AXI_BID,
                        S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RID}, 64'h0);
        S_AXI_WVALID = 1'b0;
        model_write(32'h0000_07C0, 1, 2'b01, 3'd2);
        repeat (2) @(negedge ACLK);
        ARESET = 1'b0;
        #1 check_output("midreset_awready_low", S_AXI_AWREADY, 1'b0);
        @(negedge ACLK);
        check_output("midreset_awready_high", S_AXI_AWREADY, 1'b1);
        fill_random(3, 4'hF);
        apply_write(32'h0000_0800, 3, 2'b01, 3'd2, 3, 0, 1'b0, resp);
        check_output("postreset_bresp", resp, 2'b00);
        model_write(32'h0000_0800, 3, 2'b01, 3'd2);
        apply_read(32'h0000_07C0, 3, 2'b01, 3'd2, 2'b00, 0);
        apply_read(32'h0000_0800, 3, 2'b01, 3'd2, 2'b00, 1);

        // Randomized bursts against the model.
        for (int n = 0; n < 24; n++) begin
            r_addr  = $urandom;
            r_len   = $urandom_range(0, 15);
            case ($urandom_range(0, 9))
                0:       r_burst = 2'b10;
                1, 2, 3: r_burst = 2'b00;
                default: r_burst = 2'b01;
            endcase
            r_size  = ($urandom_range(0, 7) == 0) ? 3'd1 : 3'd2;
            r_wlast = ($urandom_range(0, 7) == 0) ? $urandom_range(0, r_len) : r_len;
            fill_random(r_len, 4'h0);
            apply_write(r_addr, r_len, r_burst, r_size, r_wlast, $urandom_range(0, 3), 1'b1, resp);
            check_output("rand_bresp", resp,
                         (model_bad(r_burst, r_size) || r_wlast != r_len) ? 2'b10 : 2'b00);
            model_write(r_addr, r_len, r_burst, r_size);
            r_arburst = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'b01;
            r_arsize  = ($urandom_range(0, 7) == 0) ? 3'd0 : 3'd2;
            apply_read(r_addr, r_len, r_arburst, r_arsize,
                       model_bad(r_arburst, r_arsize) ? 2'b10 : 2'b00, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
